// File: rtl/ccd_capture_pkg.sv
// Shared definitions for the CCD capture front end, the Bayer stage and the testbench.
package ccd_capture_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StArmed    = 2'd1,
        StCapture  = 2'd2,
        StStopping = 2'd3
    } cap_state_e;

    localparam int unsigned PIX_W        = 12;
    localparam int unsigned H_ACTIVE_DEF = 1600;
    localparam int unsigned V_ACTIVE_DEF = 960;

endpackage

// File: rtl/ccd_xy_counter.sv
// X/Y pixel coordinate counters with line realignment, row saturation and sticky overrun.
module ccd_xy_counter
    import ccd_capture_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned CW       = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_frame_start,
    input  logic          i_line_end,
    input  logic          i_active,
    output logic          o_pix_ok,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_overrun
);

    localparam logic [CW-1:0] X_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_MAX  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_overrun;
    logic          w_y_room;

    assign w_y_room  = (r_y < Y_MAX);
    assign o_pix_ok  = i_active & w_y_room;
    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_overrun = r_overrun;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (i_clear) begin
                r_overrun <= 1'b0;
            end else if (i_active && !w_y_room) begin
                r_overrun <= 1'b1;
            end

            if (i_clear || i_frame_start) begin
                r_x <= '0;
                r_y <= '0;
            end else if (i_line_end) begin
                // A short line still consumes a row so the next line starts aligned.
                r_x <= '0;
                if (r_x != '0 && w_y_room) begin
                    r_y <= r_y + ONE;
                end
            end else if (o_pix_ok) begin
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= r_y + ONE;
                end else begin
                    r_x <= r_x + ONE;
                end
            end
        end
    end

endmodule

// File: rtl/ccd_frame_capture.sv
// Sensor capture front end: input registers, frame-aligned start/stop FSM, coordinate
// generation and a completed-frame counter, with a fixed two-stage output pipeline.
module ccd_frame_capture
    import ccd_capture_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned CW       = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [PIX_W-1:0] iDATA,
    input  logic             iFVAL,
    input  logic             iLVAL,
    input  logic             iStart,
    input  logic             iEnd,
    output logic [PIX_W-1:0] oDATA,
    output logic             oDVAL,
    output logic [CW-1:0]    oX_Cont,
    output logic [CW-1:0]    oY_Cont,
    output logic             oFval,
    output logic [31:0]      oFrame_Cont,
    output logic             oOverrun
);

    logic             r_fval;
    logic             r_lval;
    logic [PIX_W-1:0] r_data;
    logic             r_fval_q;
    logic             r_lval_q;
    logic             r_fval_low_seen;

    cap_state_e       r_state;
    cap_state_e       w_state_nxt;

    logic [PIX_W-1:0] r_p_data;
    logic             r_p_dval;
    logic             r_p_fval;
    logic [CW-1:0]    r_p_x;
    logic [CW-1:0]    r_p_y;
    logic [PIX_W-1:0] r_o_data;
    logic             r_o_dval;
    logic             r_o_fval;
    logic [CW-1:0]    r_o_x;
    logic [CW-1:0]    r_o_y;
    logic [31:0]      r_frame_cnt;

    logic             w_capturing;
    logic             w_fval_rise;
    logic             w_fval_fall;
    logic             w_lval_fall;
    logic             w_arm;
    logic             w_active;
    logic             w_pix_ok;
    logic [CW-1:0]    w_x;
    logic [CW-1:0]    w_y;
    logic             w_overrun;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_fval          <= 1'b0;
            r_lval          <= 1'b0;
            r_data          <= '0;
            r_fval_q        <= 1'b0;
            r_lval_q        <= 1'b0;
            r_fval_low_seen <= 1'b0;
        end else begin
            r_fval   <= iFVAL;
            r_lval   <= iLVAL;
            r_data   <= iDATA;
            r_fval_q <= r_fval;
            r_lval_q <= r_lval;
            if (!iFVAL) begin
                r_fval_low_seen <= 1'b1;
            end
        end
    end

    // A frame already in flight when reset releases must not look like a fresh start.
    assign w_fval_rise = r_fval & ~r_fval_q & r_fval_low_seen;
    assign w_fval_fall = ~r_fval & r_fval_q;
    assign w_lval_fall = ~r_lval & r_lval_q;
    assign w_capturing = (r_state == StCapture) || (r_state == StStopping);
    assign w_arm       = (r_state == StIdle) & iStart & ~iEnd;
    assign w_active    = r_fval & r_lval & w_capturing;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (iStart && !iEnd) w_state_nxt = StArmed;
            end
            StArmed: begin
                if (iEnd) w_state_nxt = StIdle;
                else if (w_fval_rise) w_state_nxt = StCapture;
            end
            StCapture: begin
                if (iEnd) w_state_nxt = StStopping;
            end
            StStopping: begin
                if (!r_fval) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    ccd_xy_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .CW       (CW)
    ) u_xy (
        .i_clk         (iClk),
        .i_rst         (iRst),
        .i_clear       (w_arm),
        .i_frame_start (w_fval_rise),
        .i_line_end    (w_lval_fall),
        .i_active      (w_active),
        .o_pix_ok      (w_pix_ok),
        .o_x           (w_x),
        .o_y           (w_y),
        .o_overrun     (w_overrun)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_p_data <= '0;
            r_p_dval <= 1'b0;
            r_p_fval <= 1'b0;
            r_p_x    <= '0;
            r_p_y    <= '0;
            r_o_data <= '0;
            r_o_dval <= 1'b0;
            r_o_fval <= 1'b0;
            r_o_x    <= '0;
            r_o_y    <= '0;
        end else begin
            r_p_data <= r_data;
            r_p_dval <= w_pix_ok;
            r_p_fval <= r_fval & w_capturing;
            r_p_x    <= w_x;
            r_p_y    <= w_y;
            r_o_data <= r_p_data;
            r_o_dval <= r_p_dval;
            r_o_fval <= r_p_fval;
            r_o_x    <= r_p_x;
            r_o_y    <= r_p_y;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_frame_cnt <= '0;
        end else if (w_fval_fall && w_capturing) begin
            r_frame_cnt <= r_frame_cnt + 32'd1;
        end
    end

    assign oDATA       = r_o_data;
    assign oDVAL       = r_o_dval;
    assign oX_Cont     = r_o_x;
    assign oY_Cont     = r_o_y;
    assign oFval       = r_o_fval;
    assign oFrame_Cont = r_frame_cnt;
    assign oOverrun    = w_overrun;

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Directed and randomized frames checked against a line/pixel-level reference model.
module tb_ccd_frame_capture;
    import ccd_capture_pkg::*;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int CW = 16;

    logic             iClk   = 1'b0;
    logic             iRst   = 1'b1;
    logic [PIX_W-1:0] iDATA  = '0;
    logic             iFVAL  = 1'b0;
    logic             iLVAL  = 1'b0;
    logic             iStart = 1'b0;
    logic             iEnd   = 1'b0;
    logic [PIX_W-1:0] oDATA;
    logic             oDVAL;
    logic [CW-1:0]    oX_Cont;
    logic [CW-1:0]    oY_Cont;
    logic             oFval;
    logic [31:0]      oFrame_Cont;
    logic             oOverrun;

    ccd_frame_capture #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .CW       (CW)
    ) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iDATA       (iDATA),
        .iFVAL       (iFVAL),
        .iLVAL       (iLVAL),
        .iStart      (iStart),
        .iEnd        (iEnd),
        .oDATA       (oDATA),
        .oDVAL       (oDVAL),
        .oX_Cont     (oX_Cont),
        .oY_Cont     (oY_Cont),
        .oFval       (oFval),
        .oFrame_Cont (oFrame_Cont),
        .oOverrun    (oOverrun)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    // Observed pixels packed as {data, x, y, cycle observed}.
    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];
    bit          fval_seen = 1'b0;

    always @(negedge iClk) begin
        if (oDVAL) obs_q.push_back({oDATA, oX_Cont, oY_Cont, 20'(cyc)});
        if (oFval) fval_seen = 1'b1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int          mx, my;
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;
    logic [11:0] seq_val;
    int          line_len[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge iClk);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_data"}, 64'(oDATA), 0);
        chk({pfx, "_dval"}, 64'(oDVAL), 0);
        chk({pfx, "_x"}, 64'(oX_Cont), 0);
        chk({pfx, "_y"}, 64'(oY_Cont), 0);
        chk({pfx, "_fval"}, 64'(oFval), 0);
        chk({pfx, "_fcnt"}, 64'(oFrame_Cont), 0);
        chk({pfx, "_ovf"}, 64'(oOverrun), 0);
    endtask

    task automatic compare_pixels();
        int n;
        chk("pix_count", 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk("pix", obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic arm();
        step();
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // One frame with line lengths from line_len; cap says whether it should be captured.
    task automatic drive_frame(input bit cap, input int end_line, input bit seq);
        fval_seen = 1'b0;
        step();
        iFVAL = 1'b1;
        if (cap) begin
            mx = 0;
            my = 0;
        end
        step(4);
        chk("fval_on", 64'(oFval), 64'(cap));
        foreach (line_len[li]) begin
            if (li == end_line) begin
                step();
                iEnd = 1'b1;
                step();
                iEnd = 1'b0;
            end
            for (int p = 0; p < line_len[li]; p++) begin
                step();
                iLVAL = 1'b1;
                iDATA = seq ? seq_val : 12'($urandom);
                if (seq) seq_val++;
                if (cap) begin
                    if (my >= V) begin
                        m_ovf = 1'b1;
                    end else begin
                        exp_q.push_back({iDATA, 16'(mx), 16'(my), 20'(cyc + 3)});
                        mx++;
                        if (mx == H) begin
                            mx = 0;
                            my++;
                        end
                    end
                end
            end
            step();
            iLVAL = 1'b0;
            iDATA = '0;
            if (cap && mx != 0) begin
                mx = 0;
                if (my < V) my++;
            end
            step(2);
        end
        step();
        iFVAL = 1'b0;
        if (cap) m_cnt++;
        step(5);
        chk("fval_off", 64'(oFval), 0);
        chk("frame_cnt", 64'(oFrame_Cont), 64'(m_cnt));
        chk("overrun", 64'(oOverrun), 64'(m_ovf));
        if (!cap) chk("no_fval", 64'(fval_seen), 0);
        compare_pixels();
    endtask

    initial begin
        // Reset held with busy inputs: every output stays 0.
        iFVAL  = 1'b1;
        iLVAL  = 1'b1;
        iDATA  = 12'habc;
        iStart = 1'b1;
        step(3);
        chk_zero("rst");

        // Release mid-frame and request capture: this frame must be ignored.
        iRst   = 1'b0;
        iStart = 1'b0;
        iLVAL  = 1'b0;
        step(2);
        m_ovf  = 1'b0;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        fval_seen = 1'b0;
        for (int p = 0; p < 4; p++) begin
            step();
            iLVAL = 1'b1;
            iDATA = 12'($urandom);
        end
        step();
        iLVAL = 1'b0;
        step(3);
        chk("midframe_dval", 64'(obs_q.size()), 0);
        chk("midframe_fval", 64'(fval_seen), 0);
        step();
        iFVAL = 1'b0;
        step(4);

        // Full frame of pixels 1..8.
        seq_val  = 12'd1;
        line_len = '{4, 4};
        drive_frame(1'b1, -1, 1'b1);

        // Short line realigns the next line.
        line_len = '{3, 4};
        drive_frame(1'b1, -1, 1'b0);

        // Extra line past V_ACTIVE: dropped and sticky overrun.
        chk("ovf_pre", 64'(oOverrun), 0);
        line_len = '{4, 4, 4};
        drive_frame(1'b1, -1, 1'b0);
        line_len = '{4};
        drive_frame(1'b1, -1, 1'b0);

        // Stop request mid-frame: frame completes, next one is ignored.
        line_len = '{4, 4};
        drive_frame(1'b1, 1, 1'b0);
        line_len = '{4, 2};
        drive_frame(1'b0, -1, 1'b0);

        // Start and stop together in idle: stop wins.
        step();
        iStart = 1'b1;
        iEnd   = 1'b1;
        step();
        iStart = 1'b0;
        iEnd   = 1'b0;
        line_len = '{4};
        drive_frame(1'b0, -1, 1'b0);

        // Randomized captured frames.
        arm();
        for (int f = 0; f < 5; f++) begin
            int nl;
            line_len.delete();
            nl = $urandom_range(1, 3);
            for (int l = 0; l < nl; l++) line_len.push_back($urandom_range(1, 7));
            drive_frame(1'b1, -1, 1'b0);
        end

        // Reset in the middle of a captured line.
        step();
        iFVAL = 1'b1;
        step(4);
        for (int p = 0; p < 2; p++) begin
            step();
            iLVAL = 1'b1;
            iDATA = 12'($urandom);
        end
        step();
        iRst = 1'b1;
        step();
        chk_zero("mrst");
        iRst = 1'b0;
        for (int p = 0; p < 2; p++) begin
            step();
            iDATA = 12'($urandom);
        end
        step();
        iLVAL = 1'b0;
        step(2);
        iFVAL = 1'b0;
        step(5);
        obs_q.delete();
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        line_len = '{4, 4};
        drive_frame(1'b0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ccd_frame_capture.md
Name: ccd_frame_capture

Overview:
- Front-end capture stage between the camera sensor pins and the Bayer-to-RGB stage. It feeds that stage, which in turn feeds the histogram/threshold pipeline.
- Registers the raw 12-bit sensor stream and qualifies it with the sensor frame/line valids.
- Generates X/Y pixel coordinates, a gated frame valid and a running frame count.
- Start/stop control is frame-aligned, so downstream stages never see a partial frame.

Parameters:
- H_ACTIVE, 1600: raw pixels per line; the X counter wraps at H_ACTIVE-1.
- V_ACTIVE, 960: raw lines per frame; lines beyond this are dropped.
- CW, 16: width of the X/Y coordinate outputs.

Ports:
- iClk  in  1  sensor pixel clock; all logic on the rising edge.
- iRst  in  1  synchronous, active-high reset.
- iDATA  in  12  raw sensor pixel.
- iFVAL  in  1  sensor frame valid.
- iLVAL  in  1  sensor line valid.
- iStart  in  1  capture enable request; level, sampled each cycle.
- iEnd  in  1  capture stop request; level, sampled each cycle.
- oDATA  out  12  registered pixel.
- oDVAL  out  1  pixel valid; oDATA/oX_Cont/oY_Cont are meaningful when high.
- oX_Cont  out  CW  column of the current oDATA.
- oY_Cont  out  CW  row of the current oDATA.
- oFval  out  1  gated frame valid to downstream.
- oFrame_Cont  out  32  count of completed captured frames.
- oOverrun  out  1  sticky; set when a line arrives past V_ACTIVE.

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; all counters and input registers clear.
- Input stage: iDATA, iFVAL and iLVAL are registered once (rFVAL, rLVAL, rDATA). Edges are detected on the registered copies.
- Latency: a pixel sampled on iDATA at edge N appears on oDATA after edge N+2, with matching oDVAL/X/Y. Fixed; no backpressure.
- FSM states:
  - IDLE: go to ARMED when iStart=1 and iEnd=0.
  - ARMED: go to CAPTURE on the rFVAL rising edge, so capture never starts mid-frame. iEnd=1 returns to IDLE.
  - CAPTURE: iEnd=1 goes to STOPPING. On the rFVAL falling edge, stay in CAPTURE.
  - STOPPING: on the rFVAL falling edge go to IDLE. If rFVAL is already low on entry, go to IDLE the next cycle.
- Simultaneous events:
  - iStart and iEnd both high: iEnd wins.
  - iStart while in CAPTURE or STOPPING: ignored.
- Output gating:
  - oFval = rFVAL while the FSM is in CAPTURE or STOPPING; otherwise 0.
  - oDVAL = rFVAL & rLVAL & (state is CAPTURE or STOPPING) & (Y < V_ACTIVE).
- X counter:
  - Increments on every cycle where the oDVAL condition holds.
  - At H_ACTIVE-1 it wraps to 0 and Y increments.
  - It also clears on the rLVAL falling edge, so a short line realigns the next line to X=0. In that case Y increments if X was not already 0.
- Y counter:
  - Clears on the rFVAL rising edge.
  - Stops at V_ACTIVE and does not increment further.
  - A valid line while Y=V_ACTIVE sets oOverrun and its pixels are dropped (oDVAL low).
- Clearing counters: X and Y clear on entering ARMED. oOverrun clears only on iRst or on leaving IDLE.
- oFrame_Cont:
  - Increments by 1 on each rFVAL falling edge while in CAPTURE or STOPPING.
  - Wraps modulo 2^32.
  - Holds across stop/start; cleared only by iRst.
- Reset mid-frame: everything returns to IDLE at the next edge. After deassertion, capture resumes only via iStart followed by the next frame start.

Decomposition:
- Shared package (ccd_capture_pkg):
  - FSM state encoding: IDLE=0, ARMED=1, CAPTURE=2, STOPPING=3.
  - Pixel width constant PIX_W=12.
  - Default H_ACTIVE/V_ACTIVE constants, shared with the Bayer stage and the testbench.
- One sub-module, ccd_xy_counter: holds the X/Y counters, the wrap/saturation logic and overrun detection. The FSM, edge detection and frame counter stay in the top.

Test Plan:
- Reset, then iStart=1 mid-frame (rFVAL already high) -> oFval/oDVAL stay 0 until the next rFVAL rise. The first pixel then appears 2 cycles later with X=0, Y=0.
- H_ACTIVE=4, V_ACTIVE=2, full frame of 8 pixels with values 1..8 -> oDATA 1..8. X runs 0,1,2,3,0,1,2,3; Y runs 0,0,0,0,1,1,1,1. oFrame_Cont=1 after FVAL falls.
- Short line of 3 pixels, LVAL drop, then a full line -> the next line starts at X=0, Y=1.
- 3 lines with V_ACTIVE=2 -> the third line's oDVAL stays 0 and oOverrun=1 (sticky) after the first pixel of line 3.
- iEnd pulsed mid-frame -> the frame completes, oFrame_Cont increments once, then oFval=0. The following frame is ignored and the count holds.
- iStart=iEnd=1 in IDLE -> the FSM stays in IDLE. iRst asserted mid-frame -> all outputs are 0 on the next edge.
